rx_mc_fir: RTL and testbench
============================

Name: rx_mc_fir

Overview:
- Parametrised multi-channel receive matched filter with symbol-phase slicer, for the DSP RX path after the channel model.
- Filters NCH parallel channels (e.g. I/Q) through one shared, runtime-reloadable coefficient bank.
- Saturates each output to the output format and produces one hard bit per channel per symbol at a selectable phase.
- Adds a double-buffered coefficient load with symbol-aligned swap and sticky per-channel saturation flags.

Parameters:
- NCH, 2, number of parallel channels
- UPSAMPLE, 4, samples per symbol (power of 2, ≥2)
- NCOEF, 24, number of taps
- COEF_NBITS / COEF_FBITS, 8 / 7, coefficient total / fractional bits (signed)
- DATA_NBITS / DATA_FBITS, 8 / 7, input sample format (signed)
- OUT_NBITS / OUT_FBITS, 8 / 7, output sample format (signed)
- COEF_INIT, all zeros, NCOEF*COEF_NBITS reset image; tap 0 in the MSBs

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  sample-rate clock enable; everything holds when low
- rx_in  in  NCH*DATA_NBITS  channel c at [c*DATA_NBITS +: DATA_NBITS]
- phase_in  in  clog2(UPSAMPLE)  symbol sampling phase
- coef_wr  in  1  write coef_data into the shadow bank at coef_addr
- coef_addr  in  clog2(NCOEF)  shadow tap index
- coef_data  in  COEF_NBITS  shadow tap value
- coef_swap  in  1  request shadow→active copy
- swap_pending  out  1  swap requested, not yet applied
- sat_clr  in  1  clear sticky saturation flags
- rx_out  out  NCH*OUT_NBITS  filtered, saturated samples
- rx_bit_out  out  NCH  hard decisions
- sym_valid  out  1  one-cycle strobe when rx_bit_out updates
- sat_sticky  out  NCH  sticky per-channel overflow flag

Behaviour:
- Reset (async, rst=1):
  - active and shadow banks ← COEF_INIT
  - phase counter, pipeline, rx_out, rx_bit_out, sym_valid, sat_sticky, swap_pending ← 0
- Arithmetic:
  - y_c[n] = Σ_k h[k]·x_c[n−k]; h[0] multiplies the newest sample.
  - Full width FW = DATA_NBITS+COEF_NBITS+clog2(NCOEF); full fractional bits FF = DATA_FBITS+COEF_FBITS.
  - No internal overflow is possible.
  - Output slice is bits [FF+OUT_NBITS−OUT_FBITS−1 : FF−OUT_FBITS], truncation.
- Saturation:
  - Triggered if any bit above the slice MSB differs from the sign bit.
  - Output clamps to +max (0x7F) or −max (0x80) by sign.
  - sat_sticky[c] is set on the clamping cycle.
- Pipeline: transposed form.
  - Stage 1: products registered.
  - Stage 2: accumulate chain.
  - Stage 3: saturate and register rx_out.
  - Latency: exactly 3 enabled cycles from rx_in to rx_out; enable low freezes all stages and the counter.
- Phase counter: cnt increments each enabled cycle and wraps UPSAMPLE−1→0.
- Decision:
  - On an enabled cycle with cnt==phase_in: rx_bit_out[c] ← ~sign(stage-2 sum of c), and sym_valid ← 1.
  - Otherwise sym_valid ← 0.
  - A phase_in change takes effect on the next compare.
- Coefficient load:
  - coef_wr writes the shadow bank only; it works regardless of enable.
  - coef_addr ≥ NCOEF is ignored.
- Swap FSM, states IDLE / PENDING:
  - coef_swap moves IDLE→PENDING; swap_pending=1 in PENDING.
  - In PENDING, on an enabled cycle with cnt==UPSAMPLE−1: active←shadow, then →IDLE.
  - New coefficients apply to products from the next enabled cycle.
  - coef_swap while PENDING is absorbed.
  - coef_wr and swap on the same cycle: the write lands before the copy.
- sat_clr:
  - Clears all flags.
  - If clear and a new saturation happen on the same cycle, set wins.
- Reset mid-operation: the whole block returns to reset values immediately, including any pending swap.

Optional Feature:
- Macro RX_MC_FIR_ROUND_EN.
- Defined: round-half-up before slicing. Add 2^(FF−OUT_FBITS−1) to the full sum, then saturate. The add is performed in FW+1 bits, so no wrap.
- Undefined: plain truncation as above.
- Latency is unchanged either way.

Decomposition:
- Package rx_mc_fir_pkg: width helper functions (FW, FF, slice bounds), SAT_MAX/SAT_MIN constants, and the swap FSM state typedef.
- One natural sub-module, rx_mc_fir_sat: combinational saturator plus optional rounding.
  - Instantiated NCH times.
  - Outputs the sliced value and an overflow flag.

Test Plan:
- Impulse, delta tap (h[0]=0x7F, rest 0): rx_in ch0 = 0x40 for one cycle, else 0 → rx_out ch0 = 0x3F exactly 3 enabled cycles later, then 0.
- Saturation: all taps 0x7F, constant 0x7F input → rx_out 0x7F and sat_sticky=1. Negate the input to 0x80 → rx_out 0x80. sat_clr with continued overflow → flag stays 1.
- Phase select: UPSAMPLE=4, phase_in=2, channels fed +/− symbols → sym_valid every 4th enabled cycle at cnt==2, and rx_bit_out = 1 for positive, 0 for negative.
- Swap: write all-0x20 taps, pulse coef_swap at cnt==1 → swap_pending high until the cnt==3 cycle, and outputs change only after it. A second coef_swap while pending → single swap.
- Enable stall: toggle enable 1010… → output sequence identical to the continuous-enable run, compressed to enabled cycles.
- Reset mid-stream: assert rst while swap is pending and sat_sticky=1 → all outputs 0, swap_pending 0, active bank = COEF_INIT.

Source files
------------

// File: rtl/rx_mc_fir_pkg.sv
// Shared widths, saturation constants and swap FSM states for the rx_mc_fir matched filter.
package rx_mc_fir_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  // Clamp patterns; the top OUT_NBITS bits give +max / -max for any output width.
  localparam logic [63:0] SAT_MAX = {1'b0, {63{1'b1}}};
  localparam logic [63:0] SAT_MIN = {1'b1, {63{1'b0}}};

  function automatic int fullWidth(input int dataNbits, input int coefNbits, input int ncoef);
    return dataNbits + coefNbits + $clog2(ncoef);
  endfunction

  function automatic int fullFbits(input int dataFbits, input int coefFbits);
    return dataFbits + coefFbits;
  endfunction

  function automatic int sliceMsb(input int ff, input int outNbits, input int outFbits);
    return ff + outNbits - outFbits - 1;
  endfunction

  function automatic int sliceLsb(input int ff, input int outFbits);
    return ff - outFbits;
  endfunction

endpackage

// File: rtl/rx_mc_fir_sat.sv
// Combinational slicer/saturator for one channel of the full-precision filter sum.
// Rounding (half-up) is included when RX_MC_FIR_ROUND_EN is defined; truncation otherwise.
module rx_mc_fir_sat
  import rx_mc_fir_pkg::*;
#(
  parameter int FW     = 21,
  parameter int SL_MSB = 14,
  parameter int SL_LSB = 7,
  parameter int ON     = 8
) (
  input  logic [FW-1:0] sum_i,
  output logic [ON-1:0] val_o,
  output logic          ovf_o
);

  localparam logic [ON-1:0] POS_MAX = SAT_MAX[63 -: ON];
  localparam logic [ON-1:0] NEG_MAX = SAT_MIN[63 -: ON];

  logic [FW:0]        ext;
  logic [FW-SL_MSB:0] upper;
  logic               unused_lsbs;

  // One guard bit so the rounding add can never wrap.
`ifdef RX_MC_FIR_ROUND_EN
  localparam logic [FW:0] HALF_LSB = (FW+1)'(1) << (SL_LSB - 1);
  assign ext = {sum_i[FW-1], sum_i} + HALF_LSB;
`else
  assign ext = {sum_i[FW-1], sum_i};
`endif

  assign upper       = ext[FW:SL_MSB];
  assign unused_lsbs = ^ext[SL_LSB-1:0];
  assign ovf_o       = !((&upper) || !(|upper));
  assign val_o       = ovf_o ? (ext[FW] ? NEG_MAX : POS_MAX) : ext[SL_MSB:SL_LSB];

endmodule

// File: rtl/rx_mc_fir.sv
// Multi-channel transposed-form RX matched filter with symbol-phase slicer and double-buffered taps.
// Optional output rounding is selected with the RX_MC_FIR_ROUND_EN macro.
module rx_mc_fir
  import rx_mc_fir_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int UPSAMPLE   = 4,
  parameter int NCOEF      = 24,
  parameter int COEF_NBITS = 8,
  parameter int COEF_FBITS = 7,
  parameter int DATA_NBITS = 8,
  parameter int DATA_FBITS = 7,
  parameter int OUT_NBITS  = 8,
  parameter int OUT_FBITS  = 7,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF_INIT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NCH*DATA_NBITS-1:0]     rx_in,
  input  logic [$clog2(UPSAMPLE)-1:0]   phase_in,
  input  logic                          coef_wr,
  input  logic [$clog2(NCOEF)-1:0]      coef_addr,
  input  logic [COEF_NBITS-1:0]         coef_data,
  input  logic                          coef_swap,
  output logic                          swap_pending,
  input  logic                          sat_clr,
  output logic [NCH*OUT_NBITS-1:0]      rx_out,
  output logic [NCH-1:0]                rx_bit_out,
  output logic                          sym_valid,
  output logic [NCH-1:0]                sat_sticky
);

  localparam int FW     = fullWidth(DATA_NBITS, COEF_NBITS, NCOEF);
  localparam int FF     = fullFbits(DATA_FBITS, COEF_FBITS);
  localparam int SL_MSB = sliceMsb(FF, OUT_NBITS, OUT_FBITS);
  localparam int SL_LSB = sliceLsb(FF, OUT_FBITS);
  localparam int PW     = DATA_NBITS + COEF_NBITS;
  localparam int CW     = $clog2(UPSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(UPSAMPLE - 1);

  logic [COEF_NBITS-1:0] active_q [NCOEF];
  logic [COEF_NBITS-1:0] shadow_q [NCOEF];
  logic [COEF_NBITS-1:0] shadow_d [NCOEF];
  logic [PW-1:0]         prod_q   [NCH][NCOEF];
  logic [PW-1:0]         prod_d   [NCH][NCOEF];
  logic [FW-1:0]         acc_q    [NCH][NCOEF];
  logic [FW-1:0]         acc_d    [NCH][NCOEF];

  logic [NCH-1:0][OUT_NBITS-1:0] rx_out_q;
  logic [NCH-1:0][OUT_NBITS-1:0] sat_val;
  logic [NCH-1:0]                ovf;
  logic [NCH-1:0]                bit_q;
  logic [NCH-1:0]                sticky_q;
  logic                          sym_valid_q;
  logic [CW-1:0]                 cnt_q;
  logic                          sym_hit;
  logic                          do_swap;
  swap_state_e                   state_q, state_d;

  assign sym_hit = enable && (cnt_q == phase_in);

  always_comb begin
    shadow_d = shadow_q;
    if (coef_wr && (int'(coef_addr) < NCOEF)) begin
      shadow_d[coef_addr] = coef_data;
    end
  end

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      IDLE:    if (coef_swap) state_d = PENDING;
      PENDING: begin
        if (enable && (cnt_q == CNT_LAST)) begin
          do_swap = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are sign-extended to the product width so the low PW bits are the exact signed product.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NCOEF; k++) begin
        prod_d[c][k] = {{COEF_NBITS{rx_in[c*DATA_NBITS + DATA_NBITS - 1]}}, rx_in[c*DATA_NBITS +: DATA_NBITS]}
                     * {{DATA_NBITS{active_q[k][COEF_NBITS-1]}}, active_q[k]};
        acc_d[c][k]  = {{(FW-PW){prod_q[c][k][PW-1]}}, prod_q[c][k]};
      end
      for (int k = 0; k < NCOEF - 1; k++) begin
        acc_d[c][k] = acc_d[c][k] + acc_q[c][k+1];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_sat
    rx_mc_fir_sat #(
      .FW    (FW),
      .SL_MSB(SL_MSB),
      .SL_LSB(SL_LSB),
      .ON    (OUT_NBITS)
    ) u_sat (
      .sum_i(acc_q[c][0]),
      .val_o(sat_val[c]),
      .ovf_o(ovf[c])
    );
  end

  // The copy takes shadow_d so a write on the swap cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        active_q[k] <= COEF_INIT[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
        shadow_q[k] <= COEF_INIT[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
      end
      state_q <= IDLE;
    end else begin
      shadow_q <= shadow_d;
      state_q  <= state_d;
      if (do_swap) active_q <= shadow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NCOEF; k++) begin
          prod_q[c][k] <= '0;
          acc_q[c][k]  <= '0;
        end
      end
      rx_out_q <= '0;
      cnt_q    <= '0;
    end else if (enable) begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      rx_out_q <= sat_val;
      cnt_q    <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Set beats clear when both happen on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q       <= '0;
      sym_valid_q <= 1'b0;
      sticky_q    <= '0;
    end else begin
      sym_valid_q <= sym_hit;
      sticky_q    <= (sat_clr ? '0 : sticky_q) | ({NCH{enable}} & ovf);
      if (sym_hit) begin
        for (int c = 0; c < NCH; c++) begin
          bit_q[c] <= ~acc_q[c][0][FW-1];
        end
      end
    end
  end

  assign rx_out       = rx_out_q;
  assign rx_bit_out   = bit_q;
  assign sym_valid    = sym_valid_q;
  assign sat_sticky   = sticky_q;
  assign swap_pending = (state_q == PENDING);

endmodule

// File: tb/tb_rx_mc_fir.sv
// Directed bench for rx_mc_fir: a direct-form reference model feeds a scoreboard queue
// that is compared against the DUT as each enabled sample leaves the pipeline.
module tb_rx_mc_fir;

  localparam int NCH   = 2;
  localparam int NCOEF = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rx_in = '0;
  logic [1:0]  phase_in = '0;
  logic        coef_wr = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic        coef_swap = 1'b0;
  logic        sat_clr = 1'b0;
  logic        swap_pending;
  logic [15:0] rx_out;
  logic [1:0]  rx_bit_out;
  logic        sym_valid;
  logic [1:0]  sat_sticky;

  rx_mc_fir dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rx_in       (rx_in),
    .phase_in    (phase_in),
    .coef_wr     (coef_wr),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .swap_pending(swap_pending),
    .sat_clr     (sat_clr),
    .rx_out      (rx_out),
    .rx_bit_out  (rx_bit_out),
    .sym_valid   (sym_valid),
    .sat_sticky  (sat_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][7:0] v;
    logic [1:0]      b;
    logic [1:0]      o;
  } item_t;

  item_t sbQ[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: tap history keeps the coefficient set in force when each sample entered.
  logic signed [7:0] actM [NCOEF];
  logic signed [7:0] shM  [NCOEF];
  logic signed [7:0] hH   [NCOEF][NCOEF];
  logic signed [7:0] xH   [NCH][NCOEF];
  int                cntM;
  logic              pendM;
  logic [1:0]        satM;
  logic [1:0]        bitsM;
  logic              validM;
  logic [1:0][7:0]   outM;

  task automatic modelReset();
    item_t prime;
    for (int k = 0; k < NCOEF; k++) begin
      actM[k] = '0;
      shM[k]  = '0;
      for (int j = 0; j < NCOEF; j++) hH[k][j] = '0;
      for (int c = 0; c < NCH; c++) xH[c][k] = '0;
    end
    cntM   = 0;
    pendM  = 1'b0;
    satM   = '0;
    bitsM  = '0;
    validM = 1'b0;
    outM   = '0;
    prime.v = '0;
    prime.b = 2'b11;
    prime.o = 2'b00;
    sbQ.delete();
    sbQ.push_back(prime);
    sbQ.push_back(prime);
  endtask

  function automatic item_t computeItem();
    item_t it;
    for (int c = 0; c < NCH; c++) begin
      int full = 0;
      int t;
      for (int k = 0; k < NCOEF; k++) full += int'(hH[k][k]) * int'(xH[c][k]);
      t = full;
`ifdef RX_MC_FIR_ROUND_EN
      t = t + 64;
`endif
      t = t >>> 7;
      if (t > 127) begin
        it.v[c] = 8'h7F;
        it.o[c] = 1'b1;
      end else if (t < -128) begin
        it.v[c] = 8'h80;
        it.o[c] = 1'b1;
      end else begin
        it.v[c] = t[7:0];
        it.o[c] = 1'b0;
      end
      it.b[c] = (full < 0) ? 1'b0 : 1'b1;
    end
    return it;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput($sformatf("%s rx_out0", tag), rx_out[7:0], outM[0]);
    checkOutput($sformatf("%s rx_out1", tag), rx_out[15:8], outM[1]);
    checkOutput($sformatf("%s sym_valid", tag), 8'(sym_valid), 8'(validM));
    checkOutput($sformatf("%s rx_bit_out", tag), 8'(rx_bit_out), 8'(bitsM));
    checkOutput($sformatf("%s sat_sticky", tag), 8'(sat_sticky), 8'(satM));
    checkOutput($sformatf("%s swap_pending", tag), 8'(swap_pending), 8'(pendM));
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                               input logic en, input logic swap, input logic clr,
                               input logic wr = 1'b0, input int addr = 0, input logic [7:0] data = 8'h00);
    item_t cur;
    logic  pendBefore;
    rx_in     = {x1, x0};
    enable    = en;
    coef_swap = swap;
    sat_clr   = clr;
    coef_wr   = wr;
    coef_addr = addr[4:0];
    coef_data = data;
    @(posedge clk);
    #1;
    pendBefore = pendM;
    if (wr && addr < NCOEF) shM[addr] = data;
    if (en) begin
      for (int k = NCOEF - 1; k > 0; k--) begin
        hH[k] = hH[k-1];
        for (int c = 0; c < NCH; c++) xH[c][k] = xH[c][k-1];
      end
      hH[0]    = actM;
      xH[0][0] = x0;
      xH[1][0] = x1;
      sbQ.push_back(computeItem());
      cur    = sbQ.pop_front();
      outM   = cur.v;
      validM = (cntM == int'(phase_in));
      if (validM) bitsM = cur.b;
      satM = (clr ? 2'b00 : satM) | cur.o;
      if (pendBefore && cntM == 3) begin
        actM  = shM;
        pendM = 1'b0;
      end
      cntM = (cntM + 1) % 4;
    end else begin
      validM = 1'b0;
      satM   = clr ? 2'b00 : satM;
    end
    if (!pendBefore && swap) pendM = 1'b1;
    checkAll(tag);
    coef_wr   = 1'b0;
    coef_swap = 1'b0;
    sat_clr   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] rx_mc_fir directed run starting");
    modelReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    // Delta tap: h[0]=0x7F; an out-of-range address must not touch the bank.
    applyStimulus("wr_h0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h7F);
    applyStimulus("wr_oob", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 25, 8'h55);
    applyStimulus("pre", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("swap_delta", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus("swap_wait", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    applyStimulus("impulse", 8'h40, 8'hC0, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus("impulse_tail", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    phase_in = 2'd2;
    for (int i = 0; i < 16; i++) begin
      applyStimulus("phase", i[2] ? 8'hC0 : 8'h40, i[2] ? 8'h40 : 8'hC0, 1'b1, 1'b0, 1'b0);
    end

    for (int k = 0; k < NCOEF; k++) applyStimulus("wr_20", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, k, 8'h20);
    while (cntM != 1) applyStimulus("align", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("swap_a", 8'h10, 8'hF0, 1'b1, 1'b1, 1'b0);
    applyStimulus("swap_b", 8'h10, 8'hF0, 1'b1, 1'b1, 1'b0);
    applyStimulus("swap_wr", 8'h10, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h10);
    for (int i = 0; i < 30; i++) begin
      applyStimulus("post_swap", 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    end

    for (int k = 0; k < NCOEF; k++) applyStimulus("wr_7f", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, k, 8'h7F);
    applyStimulus("sat_clr0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus("swap_sat", 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 36; i++) applyStimulus("sat_pos", 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus("sat_neg", 8'h80, 8'h01, 1'b1, 1'b0, i == 20);
    for (int i = 0; i < 30; i++) applyStimulus("sat_drain", 8'h00, 8'h00, 1'b1, 1'b0, i == 28);

    for (int i = 0; i < 24; i++) begin
      applyStimulus("stall", 8'($urandom), 8'($urandom), i % 2 == 0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 30; i++) applyStimulus("sat_again", 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("swap_before_rst", 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("init_bank", 8'h40, 8'h40, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus("init_bank_tail", 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
